// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with one shared period counter.
//
// Each channel has a double-buffered duty register. A load strobe captures
// duty_in into the shadow set. The shadow moves to the active set at the
// period boundary ("wrap cycle"), or on the next edge while disabled, so a
// new duty never changes a pulse mid-period.
//
// Optional feature, macro PWM_MULTI_CENTER_EN:
//   defined   - center-aligned counting 0..2^W-1..1, with a direction bit.
//               Channel offsets are forced to 0.
//   undefined - edge-aligned counting 0..2^W-1, with a modulo wrap.
//
// Parameters: WIDTH (duty/counter bits), CHANNELS (1..16),
//             INTERLEAVE (1 = channel k shifted by k*2^WIDTH/CHANNELS counts)
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        run counter; when low, counter = 0 and outputs are low
//   duty_in       packed duties, channel k at [k*WIDTH +: WIDTH]
//   load          one-cycle strobe that captures duty_in
//   load_ack      one-cycle pulse when new duties become active
//   pending       shadow holds duties that are not yet active
//   period_start  one-cycle pulse aligned with count 0 on the pins
//   pwm_out       registered PWM outputs

// Per-channel comparator and output register.
module pwm_lane #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm <= 1'b0;
    else        pwm <= enable & (pc < duty);
  end
endmodule

module pwm_multi #(
  parameter int WIDTH      = 16,
  parameter int CHANNELS   = 4,
  parameter int INTERLEAVE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      load,
  output logic                      load_ack,
  output logic                      pending,
  output logic                      period_start,
  output logic [CHANNELS-1:0]       pwm_out
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]                 cnt;
  logic [CHANNELS-1:0][WIDTH-1:0]   duty_v, shadow, active;
  logic                             wrap, xfer;

  assign duty_v = duty_in;

`ifdef PWM_MULTI_CENTER_EN
  localparam bit IL_EFF = 1'b0 && (INTERLEAVE != 0);
  logic dir_down;

  // The period ends on the last down-count (1); the next count is 0.
  assign wrap = enable & dir_down & (cnt == WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dir_down <= 1'b0;
    end else if (!enable) begin
      cnt      <= '0;
      dir_down <= 1'b0;
    end else if (!dir_down) begin
      if (cnt == CNT_MAX) begin
        dir_down <= 1'b1;
        cnt      <= cnt - 1'b1;
      end else begin
        cnt      <= cnt + 1'b1;
      end
    end else if (cnt == WIDTH'(1)) begin
      dir_down <= 1'b0;
      cnt      <= '0;
    end else begin
      cnt      <= cnt - 1'b1;
    end
  end
`else
  localparam bit IL_EFF = (INTERLEAVE != 0);

  assign wrap = enable & (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
    else             cnt <= '0;
  end
`endif

  // While disabled, every edge acts as a boundary. A block that restarts
  // therefore always uses the latest duty.
  assign xfer = wrap | ~enable;

  // period_start is aligned with the pins: it is registered from count 0,
  // just as pwm_out is registered from the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) period_start <= 1'b0;
    else        period_start <= enable & (cnt == '0);
  end

  // A load on a boundary writes active directly, so it is not delayed
  // by a whole period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      active   <= '0;
      pending  <= 1'b0;
      load_ack <= 1'b0;
    end else if (load && xfer) begin
      shadow   <= duty_v;
      active   <= duty_v;
      pending  <= 1'b0;
      load_ack <= 1'b1;
    end else if (load) begin
      shadow   <= duty_v;
      pending  <= 1'b1;
      load_ack <= 1'b0;
    end else if (xfer && pending) begin
      active   <= shadow;
      pending  <= 1'b0;
      load_ack <= 1'b1;
    end else begin
      load_ack <= 1'b0;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    localparam int OFF_I = IL_EFF ? k * ((2 ** WIDTH) / CHANNELS) : 0;
    logic [WIDTH-1:0] pc;
    // The offset addition wraps modulo 2^WIDTH.
    assign pc = cnt + WIDTH'(OFF_I);

    pwm_lane #(.WIDTH(WIDTH)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .pc     (pc),
      .duty   (active[k]),
      .pwm    (pwm_out[k])
    );
  end
endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi with WIDTH=4, CHANNELS=2, INTERLEAVE=1, in edge-aligned
// mode. A reference model advances once per driven cycle and pushes the
// expected {pwm_out, pending, load_ack, period_start}. After each edge the
// scenario pops that entry and compares it. Duty-ratio and ack-count checks
// are added on top of the per-cycle checks.
module tb_pwm_multi;
  localparam int W = 4;
  localparam int C = 2;
  localparam int P = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic           load = 1'b0;
  logic [C*W-1:0] duty_in = '0;
  logic           load_ack, pending, period_start;
  logic [C-1:0]   pwm_out;

  pwm_multi #(.WIDTH(W), .CHANNELS(C), .INTERLEAVE(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .duty_in      (duty_in),
    .load         (load),
    .load_ack     (load_ack),
    .pending      (pending),
    .period_start (period_start),
    .pwm_out      (pwm_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [4:0] sbq[$];

  // Reference state
  int                    mcnt;
  logic [C-1:0][W-1:0]   msh, mact;
  logic                  mpend;

  task automatic model_reset();
    mcnt = 0; msh = '0; mact = '0; mpend = 1'b0;
  endtask

  // Applies one clock edge with the current inputs to the model and queues
  // the outputs expected after that edge.
  task automatic model_push();
    logic [C-1:0]        ep;
    logic [C-1:0][W-1:0] d;
    logic                ack, ps;
    bit                  wrap, xfer;
    d = duty_in;
    for (int k = 0; k < C; k++)
      ep[k] = enable && (((mcnt + k * (P / C)) % P) < int'(mact[k]));
    ps   = enable && (mcnt == 0);
    wrap = enable && (mcnt == P - 1);
    xfer = wrap || !enable;
    ack  = 1'b0;
    if (load && xfer) begin
      mact = d; msh = d; mpend = 1'b0; ack = 1'b1;
    end else if (load) begin
      msh = d; mpend = 1'b1;
    end else if (xfer && mpend) begin
      mact = msh; mpend = 1'b0; ack = 1'b1;
    end
    mcnt = enable ? (mcnt + 1) % P : 0;
    sbq.push_back({ep, mpend, ack, ps});
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rst_n = 1'b0; enable = 1'b1; load = 1'b1; duty_in = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      obs = {pwm_out, pending, load_ack, period_start};
      checks++;
      if (obs !== 5'b0) $display("FAIL reset_hold cyc %0d: got %b want %b", i, obs, 5'b0);
      else passes++;
    end
    rst_n = 1'b1; enable = 1'b0; load = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      model_push();
      @(posedge clk); #1;
      obs = {pwm_out, pending, load_ack, period_start};
      checks++;
      if (obs !== sbq[0]) $display("FAIL reset_idle cyc %0d: got %b want %b", i, obs, sbq[0]);
      else passes++;
      void'(sbq.pop_front());
    end
  endtask

  task automatic test_load_basic();
    logic [4:0] obs, exp;
    int acks = 0, h0 = 0, h1 = 0;
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      load = (i == 2);
      duty_in = load ? {4'd4, 4'd4} : C*W'($urandom);
      model_push();
      @(posedge clk); #1;
      obs = {pwm_out, pending, load_ack, period_start};
      exp = sbq.pop_front();
      checks++;
      if (obs !== exp) $display("FAIL load_basic cyc %0d: got %b want %b", i, obs, exp);
      else passes++;
      if (load_ack) acks++;
      if (i >= 24) begin h0 += int'(pwm_out[0]); h1 += int'(pwm_out[1]); end
    end
    load = 1'b0;
    checks++; if (acks !== 1) $display("FAIL load_basic_acks: got %0d want 1", acks); else passes++;
    checks++; if (h0 !== 4) $display("FAIL load_basic_ch0_duty: got %0d want 4", h0); else passes++;
    checks++; if (h1 !== 4) $display("FAIL load_basic_ch1_duty: got %0d want 4", h1); else passes++;
  endtask

  task automatic test_two_loads();
    logic [4:0] obs, exp;
    int acks = 0, h0 = 0;
    for (int i = 0; i < 48; i++) begin
      load = (i == 11) || (i == 14);
      duty_in = (i == 11) ? {4'd4, 4'd3} : (i == 14) ? {4'd4, 4'd9} : C*W'($urandom);
      model_push();
      @(posedge clk); #1;
      obs = {pwm_out, pending, load_ack, period_start};
      exp = sbq.pop_front();
      checks++;
      if (obs !== exp) $display("FAIL two_loads cyc %0d: got %b want %b", i, obs, exp);
      else passes++;
      if (load_ack) acks++;
      if (i >= 32) h0 += int'(pwm_out[0]);
    end
    load = 1'b0;
    checks++; if (acks !== 1) $display("FAIL two_loads_acks: got %0d want 1", acks); else passes++;
    checks++; if (h0 !== 9) $display("FAIL two_loads_ch0_duty: got %0d want 9", h0); else passes++;
  endtask

  task automatic test_wrap_load();
    logic [4:0] obs, exp;
    int acks = 0, h0 = 0, pend_seen = 0;
    for (int i = 0; i < 24; i++) begin
      load = (i == 7);  // the model count is 15 here
      duty_in = load ? {4'd4, 4'd5} : C*W'($urandom);
      model_push();
      @(posedge clk); #1;
      obs = {pwm_out, pending, load_ack, period_start};
      exp = sbq.pop_front();
      checks++;
      if (obs !== exp) $display("FAIL wrap_load cyc %0d: got %b want %b", i, obs, exp);
      else passes++;
      if (load_ack) acks++;
      if (pending) pend_seen++;
      if (i >= 8) h0 += int'(pwm_out[0]);
    end
    load = 1'b0;
    checks++; if (acks !== 1) $display("FAIL wrap_load_acks: got %0d want 1", acks); else passes++;
    checks++; if (pend_seen !== 0) $display("FAIL wrap_load_pending: got %0d want 0", pend_seen); else passes++;
    checks++; if (h0 !== 5) $display("FAIL wrap_load_ch0_duty: got %0d want 5", h0); else passes++;
  endtask

  task automatic test_duty_extremes();
    logic [4:0] obs, exp;
    logic [3:0] dv;
    int h0;
    for (int pass = 0; pass < 2; pass++) begin
      h0 = 0;
      dv = (pass == 0) ? 4'd0 : 4'd15;
      for (int i = 0; i < 32; i++) begin
        load = (i == 5);
        duty_in = load ? {4'd4, dv} : C*W'($urandom);
        model_push();
        @(posedge clk); #1;
        obs = {pwm_out, pending, load_ack, period_start};
        exp = sbq.pop_front();
        checks++;
        if (obs !== exp) $display("FAIL duty_extreme%0d cyc %0d: got %b want %b", pass, i, obs, exp);
        else passes++;
        if (i >= 16) h0 += int'(pwm_out[0]);
      end
      load = 1'b0;
      checks++;
      if (h0 !== int'(dv)) $display("FAIL duty_extreme%0d_highs: got %0d want %0d", pass, h0, dv);
      else passes++;
    end
  endtask

  task automatic test_enable_drop();
    logic [4:0] obs, exp;
    int h0 = 0;
    for (int i = 0; i < 27; i++) begin
      load = (i == 3);
      enable = !(i >= 7 && i <= 10);  // the model count is 7 at i == 7
      duty_in = load ? {4'd4, 4'd7} : C*W'($urandom);
      model_push();
      @(posedge clk); #1;
      obs = {pwm_out, pending, load_ack, period_start};
      exp = sbq.pop_front();
      checks++;
      if (obs !== exp) $display("FAIL enable_drop cyc %0d: got %b want %b", i, obs, exp);
      else passes++;
      if (i == 7) begin
        checks++;
        if ({pwm_out, load_ack} !== 3'b001) $display("FAIL enable_drop_ack: got %b want 001", {pwm_out, load_ack});
        else passes++;
      end
      if (i == 11) begin
        checks++;
        if (period_start !== 1'b1) $display("FAIL reenable_period_start: got %b want 1", period_start);
        else passes++;
      end
      if (i >= 11) h0 += int'(pwm_out[0]);
    end
    load = 1'b0; enable = 1'b1;
    checks++; if (h0 !== 7) $display("FAIL reenable_ch0_duty: got %0d want 7", h0); else passes++;
  endtask

  task automatic test_async_reset();
    logic [4:0] obs, exp;
    int hi = 0;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      model_push();
      @(posedge clk); #1;
      obs = {pwm_out, pending, load_ack, period_start};
      exp = sbq.pop_front();
      checks++;
      if (obs !== exp) $display("FAIL pre_async cyc %0d: got %b want %b", i, obs, exp);
      else passes++;
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {pwm_out, pending, load_ack, period_start};
    checks++;
    if (obs !== 5'b0) $display("FAIL async_reset_clear: got %b want %b", obs, 5'b0);
    else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      duty_in = C*W'($urandom);
      model_push();
      @(posedge clk); #1;
      obs = {pwm_out, pending, load_ack, period_start};
      exp = sbq.pop_front();
      checks++;
      if (obs !== exp) $display("FAIL post_async cyc %0d: got %b want %b", i, obs, exp);
      else passes++;
      hi += int'(pwm_out[0]) + int'(pwm_out[1]);
    end
    checks++; if (hi !== 0) $display("FAIL post_async_duty0: got %0d want 0", hi); else passes++;
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_two_loads();
    test_wrap_load();
    test_duty_extremes();
    test_enable_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
